// File: rtl/mux_select_arbiter_pkg.sv
// Shared types and constants for the mux select arbiter.
// Build option MUX_ARB_FIXED_PRIO_EN (see rr_pick) switches to fixed priority.
package mux_arb_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  localparam int unsigned SEL_W        = 4;
  localparam logic [SEL_W-1:0] IDLE_SEL_DEF = 4'd9;
  localparam int unsigned MAX_NREQ     = 12;

  function automatic logic [MAX_NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    onehot = MAX_NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux_select_arbiter_if.sv
// Requester/consumer bundle of the mux select arbiter; master is the arbiter side.
interface mux_select_arbiter_if #(
  parameter int unsigned NREQ = 12
);
  import mux_arb_pkg::*;

  logic [NREQ-1:0]  req;
  logic             out_ready;
  logic [SEL_W-1:0] sel;
  logic [NREQ-1:0]  grant;
  logic             out_valid;
  logic [NREQ-1:0]  ack;

  modport master (input req, out_ready, output sel, grant, out_valid, ack);
  modport slave  (output req, out_ready, input sel, grant, out_valid, ack);
endinterface

// File: rtl/mux_select_arbiter_rr_pick.sv
// Combinational winner search: round robin after last_owner_i, or lowest index
// first when MUX_ARB_FIXED_PRIO_EN is defined.
module rr_pick
  import mux_arb_pkg::*;
#(
  parameter int unsigned NREQ = 12
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [SEL_W-1:0] last_owner_i,
  output logic             found_o,
  output logic [SEL_W-1:0] winner_o
);

`ifdef MUX_ARB_FIXED_PRIO_EN
  logic unused_last_owner;
  assign unused_last_owner = ^last_owner_i;

  always_comb begin
    found_o  = 1'b0;
    winner_o = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found_o && req_i[i]) begin
        found_o  = 1'b1;
        winner_o = SEL_W'(i);
      end
    end
  end
`else
  logic [SEL_W-1:0] idx;

  // Scan last+1 .. last+NREQ so the previous owner is considered last.
  always_comb begin
    found_o  = 1'b0;
    winner_o = '0;
    idx      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = SEL_W'((32'(last_owner_i) + k) % NREQ);
      if (!found_o && req_i[idx]) begin
        found_o  = 1'b1;
        winner_o = idx;
      end
    end
  end
`endif

endmodule

// File: rtl/mux_select_arbiter.sv
// Arbiter sharing the 12:1 result mux among NREQ requesters with burst limit and
// valid/ready paced beats. MUX_ARB_FIXED_PRIO_EN selects fixed priority in rr_pick.
module mux_select_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned      NREQ      = 12,
  parameter logic [SEL_W-1:0] IDLE_SEL  = IDLE_SEL_DEF,
  parameter int unsigned      MAX_BURST = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  mux_select_arbiter_if.master bus
);

  arb_state_t       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic             valid_q, valid_d;
  logic [3:0]       cnt_q, cnt_d;

  logic             found;
  logic [SEL_W-1:0] winner;
  logic [SEL_W-1:0] pick_last;
  logic [MAX_NREQ-1:0] oh_win;
  logic             xfer, own_req, arbitrate;

  // While granted sel_q is the owner; searching after it gives zero-bubble handover.
  assign pick_last = (state_q == GRANT) ? sel_q : last_q;
  assign oh_win    = onehot(winner);

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i        (bus.req),
    .last_owner_i (pick_last),
    .found_o      (found),
    .winner_o     (winner)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    grant_d   = grant_q;
    valid_d   = valid_q;
    cnt_d     = cnt_q;
    ack_d     = '0;
    arbitrate = 1'b0;
    xfer      = valid_q & bus.out_ready;
    own_req   = |(bus.req & grant_q);

    case (state_q)
      IDLE: arbitrate = 1'b1;
      GRANT: begin
        if (xfer) begin
          ack_d = grant_q;
          cnt_d = cnt_q + 4'd1;
          if (!(own_req && (cnt_q < 4'(MAX_BURST - 1)))) begin
            last_d    = sel_q;
            arbitrate = 1'b1;
          end
        end else if (!own_req) begin
          last_d    = sel_q;
          arbitrate = 1'b1;
        end
      end
      default: arbitrate = 1'b1;
    endcase

    if (arbitrate) begin
      if (found) begin
        state_d = GRANT;
        sel_d   = winner;
        grant_d = oh_win[NREQ-1:0];
        valid_d = 1'b1;
        cnt_d   = '0;
      end else begin
        state_d = IDLE;
        sel_d   = IDLE_SEL;
        grant_d = '0;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= IDLE_SEL;
      last_q  <= SEL_W'(NREQ - 1);
      grant_q <= '0;
      ack_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.grant     = grant_q;
  assign bus.out_valid = valid_q;
  assign bus.ack       = ack_q;

endmodule
